// File: rtl/vdp_vram_arb.sv
`default_nettype none
// ============================================================================
// Module   : vdp_vram_arb
// Purpose  : VRAM owner; DMA reads take priority, CPU data-port accesses use
//            free cycles via an auto-incrementing pointer and read-ahead.
// Revision : 1.0  initial release
// ============================================================================
module vdp_vram_arb #(
    parameter int VRAM_SIZE       = 8192,
    parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
    input  logic                       pxclk,
    input  logic                       reset,
    input  logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr,
    input  logic                       vdp_dma_rd_tick,
    output logic [7:0]                 vram_dout,
    input  logic                       cpu_addr_wr_tick,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic                       cpu_addr_rd_mode,
    input  logic                       cpu_data_wr_tick,
    input  logic [7:0]                 cpu_data_in,
    input  logic                       cpu_data_rd_tick,
    output logic [7:0]                 cpu_rd_data,
    output logic                       cpu_busy,
    output logic                       cpu_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_PEND = 2'd1,
        ST_RD_PEND = 2'd2,
        ST_RD_CAP  = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [VRAM_ADDR_WIDTH-1:0]   r_ptr;
    logic [7:0]                   r_wr_data;
    logic [7:0]                   r_cpu_rd_data;
    logic [7:0]                   r_vram_dout;
    logic                         r_dma_q;
    logic                         r_overrun;
    logic [7:0]                   r_mem [VRAM_SIZE];
    logic [7:0]                   r_mem_q;

    logic                         w_data_tick;
    logic                         w_mem_we;
    logic                         w_mem_re;
    logic [VRAM_ADDR_WIDTH-1:0]   w_mem_addr;
    logic                         w_ptr_inc;
    logic                         w_wr_latch;
    logic                         w_rd_cap;
    logic                         w_overrun;

    assign w_data_tick = cpu_data_wr_tick | cpu_data_rd_tick;

    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_re    = vdp_dma_rd_tick;
        w_mem_addr  = vdp_dma_rd_tick ? vdp_dma_addr : r_ptr;
        w_ptr_inc   = 1'b0;
        w_wr_latch  = 1'b0;
        w_rd_cap    = 1'b0;
        w_overrun   = w_data_tick && ((r_state != ST_IDLE) || cpu_addr_wr_tick);
        // A pointer load abandons whatever was in flight, including a capture.
        if (cpu_addr_wr_tick) begin
            w_state_nxt = cpu_addr_rd_mode ? ST_RD_PEND : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_data_wr_tick) begin
                        w_wr_latch  = 1'b1;
                        w_state_nxt = ST_WR_PEND;
                    end else if (cpu_data_rd_tick) begin
                        w_state_nxt = ST_RD_PEND;
                    end
                end
                ST_WR_PEND: begin
                    if (!vdp_dma_rd_tick) begin
                        w_mem_we    = 1'b1;
                        w_ptr_inc   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RD_PEND: begin
                    if (!vdp_dma_rd_tick) begin
                        w_mem_re    = 1'b1;
                        w_state_nxt = ST_RD_CAP;
                    end
                end
                ST_RD_CAP: begin
                    w_rd_cap    = 1'b1;
                    w_ptr_inc   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Single-port array with registered read; no reset so it maps to block RAM.
    always_ff @(posedge pxclk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= r_wr_data;
        end else if (w_mem_re) begin
            r_mem_q <= r_mem[w_mem_addr];
        end
    end

    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            r_ptr         <= '0;
            r_wr_data     <= 8'h00;
            r_cpu_rd_data <= 8'h00;
            r_vram_dout   <= 8'h00;
            r_dma_q       <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_dma_q   <= vdp_dma_rd_tick;
            r_overrun <= w_overrun;
            if (cpu_addr_wr_tick) begin
                r_ptr <= cpu_addr;
            end else if (w_ptr_inc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_wr_latch) begin
                r_wr_data     <= cpu_data_in;
                r_cpu_rd_data <= cpu_data_in;
            end else if (w_rd_cap) begin
                r_cpu_rd_data <= r_mem_q;
            end
            // DMA data is copied out one edge after the array read, then held.
            if (r_dma_q) begin
                r_vram_dout <= r_mem_q;
            end
        end
    end

    assign vram_dout   = r_vram_dout;
    assign cpu_rd_data = r_cpu_rd_data;
    assign cpu_busy    = (r_state != ST_IDLE);
    assign cpu_overrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/vdp_vram_arb.md
# vdp_vram_arb

VRAM owner and access arbiter for the VDP. It holds the VRAM array and answers the graphics FSM's DMA read requests (`vdp_dma_addr`/`vdp_dma_rd_tick`) with `vram_dout`. It also executes CPU data-port reads and writes in cycles the FSM leaves free, using an auto-incrementing address and a one-byte read-ahead buffer. It sits between the CPU bus interface and the video pipeline.

## Interface
- `VRAM_SIZE`, 8192, VRAM depth in bytes (power of two)
- `VRAM_ADDR_WIDTH`, `$clog2(VRAM_SIZE)`, address width
- `pxclk`  in  1  25 MHz pixel clock; the only clock
- `reset`  in  1  asynchronous, active-high
- `vdp_dma_addr`  in  VRAM_ADDR_WIDTH  FSM read address
- `vdp_dma_rd_tick`  in  1  one-cycle FSM read request
- `vram_dout`  out  8  FSM read data
- `cpu_addr_wr_tick`  in  1  load CPU address pointer
- `cpu_addr`  in  VRAM_ADDR_WIDTH  new pointer value
- `cpu_addr_rd_mode`  in  1  with address load: schedule read-ahead
- `cpu_data_wr_tick`  in  1  CPU data-port write
- `cpu_data_in`  in  8  write data
- `cpu_data_rd_tick`  in  1  CPU has consumed `cpu_rd_data`; schedule next read-ahead
- `cpu_rd_data`  out  8  read-ahead buffer
- `cpu_busy`  out  1  CPU operation pending
- `cpu_overrun`  out  1  one-cycle pulse: CPU data tick dropped

## Operation
- One VRAM access per `pxclk` edge. The array is single-port with a registered read, so it is BRAM-inferable. Contents are not cleared by reset.
- Priority: a DMA read always wins. A pending CPU operation executes at the first edge where `vdp_dma_rd_tick` is sampled low.
- The CPU operation FSM has three states: IDLE, WR_PEND, RD_PEND. A further single-cycle RD_CAP phase captures read data.
- Address tick in any state:
  - Aborts any pending operation.
  - Loads the pointer.
  - Enters RD_PEND if `cpu_addr_rd_mode`=1, else IDLE.
  - No overrun pulse is raised.
- Data write tick in IDLE:
  - Latch `cpu_data_in` and load `cpu_rd_data` with the same value.
  - Enter WR_PEND.
  - On execution, write the latched byte at the pointer, increment the pointer, return to IDLE.
- Data read tick in IDLE: enter RD_PEND.
  - On execution, read at the pointer.
  - On the next edge (RD_CAP), load `cpu_rd_data`, increment the pointer, return to IDLE.
  - RD_CAP is unaffected by a DMA read on that edge.
- Data tick (rd or wr) while `cpu_busy`=1: the tick is ignored and `cpu_overrun` pulses for one cycle.
  - If `cpu_addr_wr_tick` arrives on the same edge, the address tick wins; data ticks are dropped and overrun pulses.
- Pointer arithmetic is modulo `VRAM_SIZE`: VRAM_SIZE-1 wraps to 0.
- `vram_dout` holds the last DMA read result. CPU accesses never alter it.

## Timing
- Reset values: `vram_dout`=0, `cpu_rd_data`=0, `cpu_busy`=0, `cpu_overrun`=0, pointer=0, FSM=IDLE.
- Reset asserted mid-operation discards the pending write or read; the array is unchanged.
- DMA latency: `vdp_dma_rd_tick` sampled at edge E gives `vram_dout` valid after E+1. It is held until the next DMA read completes, so the FSM's capture two cycles after the tick is always correct.
- CPU tick at edge E: `cpu_busy`=1 after E. F is the first edge ≥E+1 with no DMA tick.
  - Write completes at F; `cpu_busy`=0 after F.
  - Read array access happens at F; `cpu_rd_data` valid and `cpu_busy`=0 after F+1.
- The FSM issues DMA ticks at most every other cycle, so F ≤ E+2:
  - worst-case write busy is 2 cycles;
  - worst-case read busy is 3 cycles.
- Back-to-back DMA ticks defer the CPU indefinitely. This is legal; `cpu_busy` stays high.

## Test plan
- Preload mem[0x0123]=0xA5 and tick DMA at 0x0123 on edge E -> `vram_dout`=0xA5 after E+1, held through E+4 while the CPU writes 0x5A to 0x0123.
- Address 0x1FFE write mode, then data writes 0x11, 0x22, 0x33 spaced 3 cycles apart -> mem[0x1FFE]=0x11, mem[0x1FFF]=0x22, mem[0x0000]=0x33 (wrap), pointer=0x0001.
- Address 0x0200 read mode with mem[0x0200..0x0201]=0x77,0x88 -> `cpu_rd_data`=0x77 after 2 cycles; a read tick then gives `cpu_rd_data`=0x88 and pointer=0x0202.
- DMA ticks on alternate edges and a CPU write issued on a DMA edge -> write lands on the following free edge; `cpu_busy` is high for ≤2 cycles; `vram_dout` is unaffected.
- Second data write tick on the cycle after the first -> `cpu_overrun` pulses once; only the first byte is written.
- Async reset asserted mid RD_PEND -> all outputs 0 immediately; the next address/read sequence behaves normally.
